// File: rtl/ddr_rd_return.sv
// DDR3-to-DDR4 read return re-timer: captures BL8 read data at DDR3 latency, replays it at DDR4 latency.
// Optional RD_RETURN_STATS_EN macro enables the saturating completed-read counter on rd_count.
module ddr_rd_return #(
  parameter int DDR3_CL    = 9,
  parameter int DDR4_CL    = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        ddr4_ck_t,
  input  logic        ddr4_reset_n,
  input  logic        ddr4_cs_n,
  input  logic        ddr4_act_n,
  input  logic [16:0] ddr4_adr,
  input  logic [15:0] ddr3_rdata,
  output logic [15:0] ddr4_rdata,
  output logic        ddr4_rvalid,
  output logic        err_ovf,
  output logic        err_udf,
  output logic        err_coll,
  output logic [15:0] rd_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = DDR4_CL + 3;

  logic [LW-1:0] line_q, line_d;
  logic [2:0]    gap_q, gap_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, coll_q, coll_d;
  logic          rd_cmd, accept, push, pop, empty, full, do_write, do_read;
  logic          unused_adr;

  assign unused_adr = ^ddr4_adr[13:0];

  always_comb begin
    rd_cmd   = !ddr4_cs_n && ddr4_act_n && (ddr4_adr[16:14] == 3'b101);
    // gap_q counts edges since the last accepted READ, saturating at 4
    accept   = rd_cmd && (gap_q == 3'd4);
    gap_d    = gap_q;
    if (accept)             gap_d = 3'd1;
    else if (gap_q != 3'd4) gap_d = gap_q + 3'd1;
    line_d   = {line_q[LW-2:0], accept};

    // line_q[k] marks a READ accepted k+1 edges ago; each tap spans the 4 beats of a burst
    push     = |line_q[DDR3_CL+2 -: 4];
    pop      = |line_q[DDR4_CL+2 -: 4];
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_write = push && !(empty && pop) && (!full || pop);
    do_read  = pop && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;

    rvalid_d = pop;
    rdata_d  = 16'h0000;
    if (pop) begin
      if (!empty)    rdata_d = mem_q[rd_ptr_q[AW-1:0]];
      else if (push) rdata_d = ddr3_rdata;
    end

    ovf_d  = ovf_q  || (push && full && !pop);
    udf_d  = udf_q  || (pop && empty && !push);
    coll_d = coll_q || (rd_cmd && !accept);
  end

  always_ff @(posedge ddr4_ck_t or negedge ddr4_reset_n) begin
    if (!ddr4_reset_n) begin
      line_q   <= '0;
      gap_q    <= 3'd4;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      line_q   <= line_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      coll_q   <= coll_d;
    end
  end

  always_ff @(posedge ddr4_ck_t) begin
    if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= ddr3_rdata;
  end

`ifdef RD_RETURN_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (line_q[LW-1] && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge ddr4_ck_t or negedge ddr4_reset_n) begin
    if (!ddr4_reset_n) cnt_q <= 16'h0000;
    else               cnt_q <= cnt_d;
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = 16'h0000;
`endif

  assign ddr4_rdata  = rdata_q;
  assign ddr4_rvalid = rvalid_q;
  assign err_ovf     = ovf_q;
  assign err_udf     = udf_q;
  assign err_coll    = coll_q;

endmodule

// File: tb/tb_ddr_rd_return.sv
// Directed bench for ddr_rd_return: default instance plus a shallow-FIFO/long-latency instance for overflow.
module tb_ddr_rd_return;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        act_n = 1'b1;
  logic [16:0] adr = '0;
  logic [15:0] d3 = '0;

  logic [15:0] rdata, cnt, rdata4, cnt4;
  logic        rvalid, ovf, udf, coll, rvalid4, ovf4, udf4, coll4;

  int total = 0;
  int bad   = 0;

  ddr_rd_return dut (
    .ddr4_ck_t(clk), .ddr4_reset_n(rst_n), .ddr4_cs_n(cs_n), .ddr4_act_n(act_n),
    .ddr4_adr(adr), .ddr3_rdata(d3), .ddr4_rdata(rdata), .ddr4_rvalid(rvalid),
    .err_ovf(ovf), .err_udf(udf), .err_coll(coll), .rd_count(cnt)
  );

  ddr_rd_return #(.DDR3_CL(9), .DDR4_CL(21), .FIFO_DEPTH(4)) dut4 (
    .ddr4_ck_t(clk), .ddr4_reset_n(rst_n), .ddr4_cs_n(cs_n), .ddr4_act_n(act_n),
    .ddr4_adr(adr), .ddr3_rdata(d3), .ddr4_rdata(rdata4), .ddr4_rvalid(rvalid4),
    .err_ovf(ovf4), .err_udf(udf4), .err_coll(coll4), .rd_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-READ cycles rotate through deselect, ACT, WRITE and MRS encodings
  task automatic drive(input int c, input bit rd);
    adr = {3'b000, 14'(c)};
    d3  = 16'hA500 | 16'(c & 255);
    if (rd) begin
      cs_n = 1'b0; act_n = 1'b1; adr[16:14] = 3'b101;
    end else begin
      case (c % 4)
        0:       begin cs_n = 1'b1; act_n = 1'b1; adr[16:14] = 3'b101; end
        1:       begin cs_n = 1'b0; act_n = 1'b0; adr[16:14] = 3'b101; end
        2:       begin cs_n = 1'b0; act_n = 1'b1; adr[16:14] = 3'b100; end
        default: begin cs_n = 1'b0; act_n = 1'b1; adr[16:14] = 3'b000; end
      endcase
    end
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({name, "/rst_rvalid"}, rvalid, 0);
    check({name, "/rst_rdata"},  rdata,  0);
    check({name, "/rst_flags"},  {ovf, udf, coll}, 0);
    check({name, "/rst_count"},  cnt,    0);
    rst_n = 1'b1;
  endtask

  // Data driven for edge e is A500|e, so a word launched at edge c was captured at edge c-3
  task automatic run(input string name, input int r0, input int r1, input int r2,
                     input int v_lo, input int v_hi, input int rst_c, input bit chk4,
                     input int ncyc);
    bit exp_v;
    do_reset(name);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      drive(c, (c == r0) || (c == r1) || (c == r2));
      @(posedge clk);
      #1;
      exp_v = (c >= v_lo) && (c <= v_hi) && ((rst_c == 0) || (c <= rst_c));
      check($sformatf("%s/rvalid@%0d", name, c), rvalid, exp_v);
      check($sformatf("%s/rdata@%0d", name, c), rdata,
            exp_v ? (16'hA500 | 16'((c - 3) & 255)) : 16'h0000);
      if (chk4) begin
        if (c == 22) check("ovf4/no_ovf_yet", ovf4, 0);
        if (c == 23) check("ovf4/ovf_set", ovf4, 1);
        if (c == 31) check("ovf4/first_word", {rvalid4, rdata4}, {1'b1, 16'hA513});
        if (c == 34) check("ovf4/last_word", {rvalid4, rdata4}, {1'b1, 16'hA516});
        if (c == 34) check("ovf4/no_udf_yet", udf4, 0);
        if (c == 35) check("ovf4/udf_word", {rvalid4, rdata4}, {1'b1, 16'h0000});
        if (c == 35) check("ovf4/udf_set", {udf4, coll4}, 2'b10);
`ifdef RD_RETURN_STATS_EN
        if (c == 40) check("ovf4/count", cnt4, 2);
`else
        if (c == 40) check("ovf4/count", cnt4, 0);
`endif
      end
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s/async_rvalid", name), rvalid, 0);
        check($sformatf("%s/async_rdata", name), rdata, 0);
        check($sformatf("%s/async_flags", name), {ovf, udf, coll}, 0);
      end
      if ((rst_c != 0) && (c == rst_c + 1)) rst_n = 1'b1;
    end
    @(negedge clk);
    cs_n = 1'b1;
  endtask

  initial begin
    run("single", 10, 0, 0, 22, 25, 0, 1'b0, 40);
    check("single/flags", {ovf, udf, coll}, 0);

    run("stream2", 10, 14, 0, 22, 29, 0, 1'b1, 45);
    check("stream2/flags", {ovf, udf, coll}, 0);

    run("collide", 10, 12, 0, 22, 25, 0, 1'b0, 40);
    check("collide/coll", coll, 1);
    check("collide/other_flags", {ovf, udf}, 0);

    run("stream3", 10, 14, 18, 22, 33, 0, 1'b0, 45);
    check("stream3/flags", {ovf, udf, coll}, 0);
`ifdef RD_RETURN_STATS_EN
    check("stream3/count", cnt, 3);
`else
    check("stream3/count", cnt, 0);
`endif

    run("rst_at20", 10, 0, 0, 22, 25, 20, 1'b0, 40);
    check("rst_at20/flags", {ovf, udf, coll}, 0);

    run("rst_at23", 10, 0, 0, 22, 25, 23, 1'b0, 40);
    check("rst_at23/flags", {ovf, udf, coll}, 0);
    check("rst_at23/count", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
